// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC/nPC load sequencing, delayed branches, stalls, exception redirect and imem fetch handshake
module pc_fetch_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int          MAX_WAIT   = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_q,
  input  logic [31:0] npc_q,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic        pc_load,
  output logic        npc_load,
  output logic [31:0] pc_d,
  output logic [31:0] npc_d,
  output logic        ifid_valid,
  output logic        fetch_timeout
);
  typedef enum logic [1:0] {BOOT, REQ, HOLD, DRAIN} state_t;
  state_t      state, state_nx;
  logic        pend_v;
  logic [31:0] pend_t;
  logic [7:0]  wait_cnt;
  logic        timeout_q;
  logic        in_req, in_hold, in_drain, exc, advance, waiting, hit_max;
  // Classify this cycle: exception redirect beats advance; the async-reset state register forces BOOT, so everything idles during Reset
  always_comb begin
    in_req   = state == REQ;
    in_hold  = state == HOLD;
    in_drain = state == DRAIN;
    exc      = exc_req && (in_req || in_hold || in_drain);
    advance  = !exc && !hazard_stall && ((in_req && imem_ack) || in_hold);
    waiting  = !exc && !imem_ack && (in_req || in_drain);
    hit_max  = ({1'b0, wait_cnt} + 9'd1) >= 9'(MAX_WAIT);
    state_nx = state == BOOT ? REQ :
               exc ? (((in_req || in_drain) && !imem_ack) ? DRAIN : REQ) :
               in_req ? ((imem_ack && hazard_stall) ? HOLD : REQ) :
               in_hold ? (hazard_stall ? HOLD : REQ) :
               (imem_ack ? REQ : DRAIN);
  end
  // Load enables, next PC/nPC values and the fetch request; a fresh branch outranks a pending one
  always_comb begin
    pc_load       = advance || exc;
    npc_load      = advance || exc;
    ifid_valid    = advance;
    pc_d          = exc ? EXC_VECTOR : advance ? npc_q : '0;
    npc_d         = exc ? EXC_VECTOR + 32'd4 :
                    advance ? (branch_taken ? branch_target : pend_v ? pend_t : npc_q + 32'd4) : '0;
    imem_req      = in_req;
    imem_addr     = in_req ? pc_q : '0;
    fetch_timeout = timeout_q;
  end
  // State, pending branch, saturating wait counter and sticky timeout flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= BOOT;
      pend_v    <= 1'b0;
      pend_t    <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nx;
      pend_v    <= (exc || advance) ? 1'b0 : branch_taken ? 1'b1 : pend_v;
      pend_t    <= (!exc && !advance && branch_taken) ? branch_target : pend_t;
      wait_cnt  <= waiting ? (hit_max ? 8'(MAX_WAIT) : wait_cnt + 8'd1) : '0;
      timeout_q <= timeout_q || (waiting && hit_max);
    end
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed plus randomized check of pc_fetch_sequencer against a behavioural model
module tb_pc_fetch_sequencer;
  localparam logic [31:0] EXC = 32'h0000_0080;
  localparam int          MW  = 4;
  logic        Clk = 0, Reset = 1;
  logic [31:0] pc_q = 0, npc_q = 4, branch_target = 0;
  logic        hazard_stall = 0, branch_taken = 0, exc_req = 0, imem_ack = 0;
  logic        imem_req, pc_load, npc_load, ifid_valid, fetch_timeout;
  logic [31:0] imem_addr, pc_d, npc_d;
  int          total = 0, bad = 0;
  bit          m_boot, m_have, m_abandon, m_pv, m_to;
  logic [31:0] m_pt;
  int          m_waits;
  bit          n_boot, n_have, n_abandon, n_pv, n_to;
  logic [31:0] n_pt, n_pc, n_npc;
  int          n_waits;
  logic        s_req, s_load, s_ifid, s_to;
  logic [31:0] s_addr, s_pcd, s_npcd;

  pc_fetch_sequencer #(.EXC_VECTOR(EXC), .MAX_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .pc_q(pc_q), .npc_q(npc_q), .hazard_stall(hazard_stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .exc_req(exc_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .pc_load(pc_load),
    .npc_load(npc_load), .pc_d(pc_d), .npc_d(npc_d), .ifid_valid(ifid_valid),
    .fetch_timeout(fetch_timeout)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then let the edge happen
  task automatic step(input bit ack, input bit st, input bit bt, input logic [31:0] bta, input bit ex);
    logic        e_req, e_load, e_ifid;
    logic [31:0] e_addr, e_pcd, e_npcd;
    bit          fetching, live, deliver, adv;
    imem_ack = ack; hazard_stall = st; branch_taken = bt; branch_target = bta; exc_req = ex;
    #1;
    e_req = 0; e_load = 0; e_ifid = 0; e_addr = 0; e_pcd = 0; e_npcd = 0;
    n_boot = 0; n_have = m_have; n_abandon = m_abandon; n_pv = m_pv; n_pt = m_pt;
    n_waits = m_waits; n_to = m_to; n_pc = pc_q; n_npc = npc_q;
    if (m_boot) begin
      if (bt) begin n_pv = 1; n_pt = bta; end
    end else begin
      fetching = !m_have && !m_abandon;
      live     = fetching || m_abandon;
      e_req    = fetching;
      e_addr   = fetching ? pc_q : 32'd0;
      if (ex) begin
        e_load = 1; e_pcd = EXC; e_npcd = EXC + 32'd4;
        n_pv = 0; n_waits = 0; n_have = 0; n_abandon = live && !ack;
      end else begin
        deliver = (fetching && ack) || m_have;
        adv     = deliver && !st;
        if (adv) begin
          e_load = 1; e_ifid = 1; e_pcd = npc_q;
          e_npcd = bt ? bta : m_pv ? m_pt : npc_q + 32'd4;
          n_pv = 0; n_have = 0;
        end else begin
          n_have = deliver;
          if (bt) begin n_pv = 1; n_pt = bta; end
        end
        if (m_abandon && ack) n_abandon = 0;
        if (live && !ack) begin
          n_waits = (m_waits + 1 > MW) ? MW : m_waits + 1;
          if (n_waits == MW) n_to = 1;
        end else if (live) n_waits = 0;
      end
      if (e_load) begin n_pc = e_pcd; n_npc = e_npcd; end
    end
    s_req = imem_req; s_addr = imem_addr; s_load = pc_load; s_ifid = ifid_valid;
    s_pcd = pc_d; s_npcd = npc_d; s_to = fetch_timeout;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, e_addr);
    chk("pc_load", 32'(pc_load), 32'(e_load));
    chk("npc_load", 32'(npc_load), 32'(e_load));
    chk("ifid_valid", 32'(ifid_valid), 32'(e_ifid));
    chk("pc_d", pc_d, e_pcd);
    chk("npc_d", npc_d, e_npcd);
    chk("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
    @(posedge Clk);
    #1;
    m_boot = n_boot; m_have = n_have; m_abandon = n_abandon; m_pv = n_pv; m_pt = n_pt;
    m_waits = n_waits; m_to = n_to; pc_q = n_pc; npc_q = n_npc;
  endtask

  // Assert Reset mid-cycle with provocative inputs; outputs must drop at once
  task automatic do_reset();
    @(negedge Clk);
    imem_ack = 1; exc_req = 1; branch_taken = 1; hazard_stall = 0;
    Reset = 1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_load", 32'({pc_load, npc_load, ifid_valid}), 32'd0);
    chk("rst_pcd", pc_d, 32'd0);
    chk("rst_npcd", npc_d, 32'd0);
    chk("rst_to", 32'(fetch_timeout), 32'd0);
    m_boot = 1; m_have = 0; m_abandon = 0; m_pv = 0; m_pt = 0; m_waits = 0; m_to = 0;
    pc_q = 0; npc_q = 4;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
  endtask

  initial begin
    do_reset();
    step(1, 0, 0, 0, 0);
    chk("boot_req", 32'(s_req), 32'd0);
    chk("boot_load", 32'(s_load), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      chk("seq_addr", s_addr, 32'(4 * i));
      chk("seq_npcd", s_npcd, 32'(4 * i + 8));
      chk("seq_ifid", 32'(s_ifid), 32'd1);
    end
    pc_q = 32'h10; npc_q = 32'h14;
    step(1, 0, 1, 32'h200, 0);
    chk("br_pcd", s_pcd, 32'h14);
    chk("br_npcd", s_npcd, 32'h200);
    step(1, 0, 0, 0, 0);
    chk("br2_pcd", s_pcd, 32'h200);
    chk("br2_npcd", s_npcd, 32'h204);
    step(1, 1, 0, 0, 0);
    chk("st1_load", 32'(s_load), 32'd0);
    step(0, 1, 1, 32'h300, 0);
    chk("st2_load", 32'(s_load), 32'd0);
    chk("st2_req", 32'(s_req), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("st3_load", 32'(s_load), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("st_adv_ifid", 32'(s_ifid), 32'd1);
    chk("st_adv_pcd", s_pcd, 32'h204);
    chk("st_adv_npcd", s_npcd, 32'h300);
    step(1, 0, 0, 0, 0);
    chk("st_req", 32'(s_req), 32'd1);
    chk("st_addr", s_addr, 32'h204);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0);
      chk("to_req", 32'(s_req), 32'd1);
      chk("to_early", 32'(s_to), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    chk("to_set", 32'(s_to), 32'd1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("to_sticky", 32'(s_to), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("exc_pcd", s_pcd, EXC);
    chk("exc_npcd", s_npcd, EXC + 32'd4);
    chk("exc_ifid", 32'(s_ifid), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("drain_req", 32'(s_req), 32'd0);
    step(1, 0, 0, 0, 0);
    chk("drain_ifid", 32'(s_ifid), 32'd0);
    chk("drain_load", 32'(s_load), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("post_exc_addr", s_addr, EXC);
    chk("post_exc_req", 32'(s_req), 32'd1);
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 32'h500, 0);
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("rb_boot", 32'(s_req), 32'd0);
    step(1, 0, 0, 0, 0);
    chk("rb_addr", s_addr, 32'd0);
    chk("rb_pcd", s_pcd, 32'd4);
    chk("rb_npcd", s_npcd, 32'd8);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      step($urandom_range(9) < 6, $urandom_range(9) < 3, $urandom_range(19) < 3,
           $urandom, $urandom_range(19) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
